// File: rtl/bcd_pkg.sv
// bcd_pkg: packed-BCD price type (4 digits) and its bounds
package bcd_pkg;
  typedef logic [15:0] price_t;
  localparam price_t PRICE_MAX = 16'h9999;
  localparam price_t PRICE_MIN = 16'h0000;
endpackage

// File: rtl/ob_pkg.sv
// ob_pkg: order-book command/response types, table entry and side-dependent helpers
package ob_pkg;
  import bcd_pkg::*;
  typedef logic [7:0] uid_t;
  typedef logic [15:0] qty_t;
  typedef enum logic [1:0] {CMD_INSERT, CMD_DELETE, CMD_AMEND, CMD_FILL} cmd_op_t;
  typedef enum logic [1:0] {RSP_OK, RSP_MISS, RSP_REJECT, RSP_EMPTY} rsp_status_t;
  typedef struct packed {
    uid_t   uid;
    price_t price;
    qty_t   quantity;
  } table_t;
  localparam table_t TABLE_ASK_INIT = '{uid: '0, price: PRICE_MAX, quantity: '0};
  localparam table_t TABLE_BID_INIT = '{uid: '0, price: PRICE_MIN, quantity: '0};
  // true when price a ranks at or ahead of price b on the given side
  function automatic logic price_better_eq(input price_t a, input price_t b, input logic is_ask);
    return is_ask ? (a <= b) : (a >= b);
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && c != '1) ? c + 32'd1 : c;
  endfunction
endpackage

// File: rtl/ob_reject_fifo.sv
// ob_reject_fifo: REJECT_N-deep FIFO of rejected/evicted entries; pop on empty is ignored
module ob_reject_fifo
  import ob_pkg::*;
#(
  parameter int REJECT_N = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  table_t push_data,
  input  logic   pop,
  output table_t front,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(REJECT_N);
  localparam int CW = $clog2(REJECT_N + 1);
  table_t mem [REJECT_N];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == CW'(REJECT_N);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign front = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < REJECT_N; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= push_data;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ob_table_mq.sv
// ob_table_mq: sorted one-side price table (head at N-1) with command port and reject FIFO
// Optional OB_TABLE_MQ_STATS_EN adds saturating insert/delete/reject/fill counters.
module ob_table_mq
  import ob_pkg::*;
#(
  parameter int N = 16,
  parameter int REJECT_N = 4,
  parameter bit IS_ASK = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  cmd_op_t                cmd_op,
  input  table_t                 cmd_tbl,
  output logic                   rsp_vld_r,
  output rsp_status_t            rsp_status_r,
  output table_t                 rsp_tbl_r,
  output logic                   head_vld_r,
  output table_t                 head_r,
  output logic [$clog2(N+1)-1:0] occ_r,
  output logic                   reject_vld_r,
  output table_t                 reject_r,
  input  logic                   reject_pop
`ifdef OB_TABLE_MQ_STATS_EN
  ,
  output logic [31:0]            stat_ins_r,
  output logic [31:0]            stat_del_r,
  output logic [31:0]            stat_rej_r,
  output logic [31:0]            stat_fill_r
`endif
);
  localparam int OW = $clog2(N + 1);
  localparam table_t INIT = IS_ASK ? TABLE_ASK_INIT : TABLE_BID_INIT;
  table_t tbl [N];
  table_t tbl_nx [N];
  table_t lo [N];
  table_t hi [N];
  logic [N-1:0] v, v_nx, lo_v, hi_v, hit, keep, rm, md;
  table_t hit_ent, rsp_nx, push_data;
  rsp_status_t st_nx;
  qty_t mq;
  logic acc, full, is_hit, ins, push, fifo_full, fifo_empty, sh, past;
  assign cmd_rdy = !fifo_full;
  assign acc = cmd_vld && cmd_rdy;
  assign full = v[0];
  assign is_hit = |hit;
  assign head_vld_r = v[N-1];
  assign head_r = tbl[N-1];
  assign reject_vld_r = !fifo_empty;
  assign lo_v = {v[N-2:0], 1'b0};
  assign hi_v = {1'b0, v[N-1:1]};
  always_comb begin
    hit_ent = '0;
    lo[0] = INIT;
    hi[N-1] = INIT;
    for (int i = 1; i < N; i++) begin
      lo[i] = tbl[i-1];
      hi[i-1] = tbl[i];
    end
    for (int i = 0; i < N; i++) begin
      hit[i] = v[i] && tbl[i].uid == cmd_tbl.uid;
      keep[i] = v[i] && price_better_eq(tbl[i].price, cmd_tbl.price, IS_ASK);
      if (hit[i]) hit_ent = tbl[i];
    end
  end
  // decode the accepted command into removal, in-place quantity and insert actions
  always_comb begin
    rm = '0;
    md = '0;
    mq = cmd_tbl.quantity;
    ins = 1'b0;
    push = 1'b0;
    push_data = cmd_tbl;
    st_nx = RSP_OK;
    rsp_nx = cmd_tbl;
    if (acc)
      case (cmd_op)
        CMD_INSERT:
          if (cmd_tbl.quantity == '0 || (full && keep[0])) begin
            st_nx = RSP_REJECT;
            push = 1'b1;
          end else begin
            ins = 1'b1;
            push = full;
            push_data = tbl[0];
          end
        CMD_DELETE, CMD_AMEND:
          if (!is_hit) st_nx = RSP_MISS;
          else if (cmd_op == CMD_DELETE || cmd_tbl.quantity == '0) begin
            rm = hit;
            rsp_nx = hit_ent;
          end else begin
            md = hit;
            rsp_nx = '{uid: hit_ent.uid, price: hit_ent.price, quantity: cmd_tbl.quantity};
          end
        CMD_FILL:
          if (!v[N-1]) st_nx = RSP_EMPTY;
          else if (cmd_tbl.quantity < tbl[N-1].quantity) begin
            md[N-1] = 1'b1;
            mq = tbl[N-1].quantity - cmd_tbl.quantity;
            rsp_nx = '{uid: tbl[N-1].uid, price: tbl[N-1].price, quantity: mq};
          end else begin
            rm[N-1] = 1'b1;
            rsp_nx = '{uid: tbl[N-1].uid, price: tbl[N-1].price, quantity: '0};
          end
      endcase
  end
  // walk from head to tail: removal pulls entries up, insertion pushes them down
  always_comb begin
    sh = 1'b0;
    past = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      sh = sh | rm[i];
      tbl_nx[i] = tbl[i];
      v_nx[i] = v[i];
      if (md[i]) tbl_nx[i].quantity = mq;
      if (sh) begin
        tbl_nx[i] = lo[i];
        v_nx[i] = lo_v[i];
      end
      if (ins && !keep[i]) begin
        tbl_nx[i] = past ? hi[i] : cmd_tbl;
        v_nx[i] = past ? hi_v[i] : 1'b1;
        past = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tbl[i] <= INIT;
      v <= '0;
      occ_r <= '0;
      rsp_vld_r <= 1'b0;
      rsp_status_r <= RSP_OK;
      rsp_tbl_r <= '0;
    end else begin
      tbl <= tbl_nx;
      v <= v_nx;
      occ_r <= occ_r + OW'(ins && !full) - OW'(|rm);
      rsp_vld_r <= acc;
      if (acc) begin
        rsp_status_r <= st_nx;
        rsp_tbl_r <= rsp_nx;
      end
    end
  ob_reject_fifo #(.REJECT_N(REJECT_N)) u_rej (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (reject_pop),
    .front     (reject_r),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`ifdef OB_TABLE_MQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_ins_r <= '0;
      stat_del_r <= '0;
      stat_rej_r <= '0;
      stat_fill_r <= '0;
    end else begin
      stat_ins_r <= sat_inc(stat_ins_r, acc && cmd_op == CMD_INSERT);
      stat_del_r <= sat_inc(stat_del_r, acc && cmd_op == CMD_DELETE);
      stat_rej_r <= sat_inc(stat_rej_r, push);
      stat_fill_r <= sat_inc(stat_fill_r, acc && cmd_op == CMD_FILL);
    end
`endif
  // UIDs must be unique within the book
  assert property (@(posedge clk) disable iff (!rst_n) !(acc && cmd_op == CMD_INSERT && is_hit));
endmodule
